axis_i2c_arbiter: RTL and testbench
===================================

Name: axis_i2c_arbiter

Overview:
- Shares one axis_i2c_master between NUM_REQ command sources, for example several config generators or a CPU bridge.
- Grants one requester per transaction (a command burst ending in tlast) and forwards its AXIS beats to the master's s_axis.
- Routes the master's m_axis read data back to the owning requester.
- Sits between requesters and axis_i2c_master in the i2c_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, command word width (matches master s_axis).
- RD_DATA_WIDTH, 8, read-data width (matches master m_axis).
- HOLD_CYCLES, 64, idle cycles ownership is held after tlast to collect read data.

Ports:
- clk_i  in  1  i2c clock domain.
- arst_i  in  1  asynchronous, active-high reset.
- req_tdata_i  in  NUM_REQ*DATA_WIDTH  requester command data, requester k in slice k.
- req_tvalid_i  in  NUM_REQ  per-requester valid.
- req_tlast_i  in  NUM_REQ  per-requester end of transaction.
- req_tready_o  out  NUM_REQ  per-requester ready.
- cmd_tdata_o  out  DATA_WIDTH  to master s_axis.
- cmd_tvalid_o  out  1  to master s_axis.
- cmd_tlast_o  out  1  to master s_axis.
- cmd_tready_i  in  1  from master s_axis.
- rsp_tdata_i  in  RD_DATA_WIDTH  from master m_axis.
- rsp_tvalid_i  in  1  from master m_axis.
- rsp_tready_o  out  1  to master m_axis.
- req_rsp_tdata_o  out  NUM_REQ*RD_DATA_WIDTH  read data, broadcast to all slices.
- req_rsp_tvalid_o  out  NUM_REQ  valid asserted only on the owner's bit.
- req_rsp_tready_i  in  NUM_REQ  per-requester response ready.
- grant_o  out  NUM_REQ  one-hot registered owner, all zero when idle.
- busy_o  out  1  high in GRANT or HOLD.
- drop_cnt_o  out  8  saturating count of responses dropped in IDLE.

Behaviour:
- Reset (arst_i high, asynchronous):
  - state is IDLE; grant_o, busy_o and drop_cnt_o are 0.
  - rr pointer is 0; hold counter is 0.
  - all tvalid/tready outputs are 0 except rsp_tready_o, which is 1 (IDLE sink).
  - Reset mid-transaction aborts with no further beats forwarded.
- States: IDLE, GRANT, HOLD.
- IDLE:
  - When any req_tvalid_i is set, select the first requester at or after the rr pointer (wrap modulo NUM_REQ).
  - Register grant_o one-hot, go to GRANT.
  - Latency: tvalid at cycle N gives grant_o at N+1 and the first beat forwarded at N+1.
  - req_tready_o is all 0.
  - rsp_tready_o is 1; each rsp handshake is dropped and increments drop_cnt_o, saturating at 255.
- GRANT (owner g):
  - cmd_* = req_*[g] combinationally; req_tready_o[g] = cmd_tready_i; other requesters' ready is 0.
  - A beat with tvalid&tready&tlast moves to HOLD, loads the hold counter with HOLD_CYCLES-1, and sets rr pointer to g+1 (wrap NUM_REQ-1 to 0).
  - A tvalid gap from the owner does not release the grant.
- Response path (GRANT and HOLD):
  - req_rsp_tvalid_o[g] = rsp_tvalid_i; rsp_tready_o = req_rsp_tready_i[g]; req_rsp_tdata_o = rsp_tdata_i, broadcast.
  - No buffering, zero latency.
- HOLD:
  - cmd_tvalid_o is 0; the counter decrements each cycle.
  - Any rsp handshake reloads the counter to HOLD_CYCLES-1.
  - Counter at 0 with no handshake that cycle returns to IDLE; grant_o clears the next cycle.
  - A new request pending at HOLD exit is arbitrated in IDLE, giving one dead cycle minimum between transactions.
- Simultaneous events:
  - tlast in the same cycle as a response handshake: both complete, response goes to g.
  - HOLD exit in the same cycle as a response handshake: stay in HOLD, counter reloaded.
- A single-beat transaction (tvalid&tlast on the first beat) goes directly to HOLD.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: IDLE selection is strict fixed priority with index 0 highest; the rr pointer is unused and is optimised away.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req 1 sends 3 beats (0x5A01, 0x5A02, 0x5A03 with tlast); cmd_tready_i held at 1:
  - grant_o=0010 one cycle after tvalid; cmd_tdata_o sequence matches; HOLD entered.
  - grant_o clears HOLD_CYCLES+1 cycles after tlast.
- All 4 requesters continuously valid, 1-beat transactions:
  - grant order 0,1,2,3,0; exactly 1 IDLE cycle between grants.
  - With ARB_FIXED_PRIO_EN: req 0 granted every time.
- Req 2 transaction, then master returns rsp 0xA5 twenty cycles after tlast with req_rsp_tready_i[2]=0 for 3 cycles:
  - only req_rsp_tvalid_o[2] is high and data is held stable.
  - hold counter is reloaded after the handshake.
- 300 responses injected while IDLE: drop_cnt_o saturates at 255; no req_rsp_tvalid_o asserted.
- arst_i pulsed mid-burst after beat 2 of 4:
  - cmd_tvalid_o and grant_o drop to 0 asynchronously.
  - After release, req 0 has priority (pointer 0).
- Owner stalls tvalid for 50 cycles mid-burst while req 3 is valid: grant is held, and req_tready_o[3] stays 0 throughout.

Source files
------------

// File: rtl/axis_i2c_arbiter.sv
// Shares one AXIS I2C master between NUM_REQ command sources with per-transaction ownership.
// Define ARB_FIXED_PRIO_EN for strict fixed priority (index 0 highest) instead of round-robin.
module axis_i2c_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_DATA_WIDTH = 8,
    parameter int HOLD_CYCLES   = 64
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_tdata_i,
    input  logic [NUM_REQ-1:0]                req_tvalid_i,
    input  logic [NUM_REQ-1:0]                req_tlast_i,
    output logic [NUM_REQ-1:0]                req_tready_o,
    output logic [DATA_WIDTH-1:0]             cmd_tdata_o,
    output logic                              cmd_tvalid_o,
    output logic                              cmd_tlast_o,
    input  logic                              cmd_tready_i,
    input  logic [RD_DATA_WIDTH-1:0]          rsp_tdata_i,
    input  logic                              rsp_tvalid_i,
    output logic                              rsp_tready_o,
    output logic [NUM_REQ*RD_DATA_WIDTH-1:0]  req_rsp_tdata_o,
    output logic [NUM_REQ-1:0]                req_rsp_tvalid_o,
    input  logic [NUM_REQ-1:0]                req_rsp_tready_i,
    output logic [NUM_REQ-1:0]                grant_o,
    output logic                              busy_o,
    output logic [7:0]                        drop_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_W-1:0]      r_owner;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_hold_cnt;
    logic [7:0]            r_drop_cnt;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [IDX_W-1:0]      w_owner_next;
    logic                  w_last_hs;
    logic                  w_rsp_hs;
    logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_req_data[gi] = req_tdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_tvalid_i[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_rr_ptr;

    // Scan from the farthest offset down so the nearest valid requester at/after the pointer wins.
    always_comb begin
        int v_k;
        w_sel_idx = '0;
        v_k       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            v_k = (int'(r_rr_ptr) + i) % NUM_REQ;
            if (req_tvalid_i[v_k]) begin
                w_sel_idx = IDX_W'(v_k);
            end
        end
    end
`endif

    assign w_owner_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_last_hs    = cmd_tvalid_o & cmd_tready_i & cmd_tlast_o;
    assign w_rsp_hs     = rsp_tvalid_i & rsp_tready_o;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_drop_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rsp_hs && (r_drop_cnt != 8'hFF)) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                    if (|req_tvalid_i) begin
                        r_state <= S_GRANT;
                        r_owner <= w_sel_idx;
                        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
                        r_busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_last_hs) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= HOLD_RELOAD;
`ifndef ARB_FIXED_PRIO_EN
                        r_rr_ptr   <= w_owner_next;
`endif
                    end
                end
                S_HOLD: begin
                    // Late read data keeps ownership alive so it still reaches the owner.
                    if (w_rsp_hs) begin
                        r_hold_cnt <= HOLD_RELOAD;
                    end else if (r_hold_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cmd_tdata_o      = w_req_data[r_owner];
        cmd_tvalid_o     = 1'b0;
        cmd_tlast_o      = 1'b0;
        req_tready_o     = '0;
        rsp_tready_o     = 1'b1;
        req_rsp_tvalid_o = '0;
        if (r_state == S_GRANT) begin
            cmd_tvalid_o = req_tvalid_i[r_owner];
            cmd_tlast_o  = req_tlast_i[r_owner];
            req_tready_o = r_grant & {NUM_REQ{cmd_tready_i}};
        end
        if ((r_state == S_GRANT) || (r_state == S_HOLD)) begin
            rsp_tready_o     = req_rsp_tready_i[r_owner];
            req_rsp_tvalid_o = r_grant & {NUM_REQ{rsp_tvalid_i}};
        end
    end

    assign req_rsp_tdata_o = {NUM_REQ{rsp_tdata_i}};
    assign grant_o         = r_grant;
    assign busy_o          = r_busy;
    assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Scenario-driven bench for axis_i2c_arbiter with a timeline-level ownership model for random traffic.
module tb_axis_i2c_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int RW = 8;
    localparam int H  = 64;

    logic            clk = 1'b0;
    logic            arst;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid, req_tlast, req_tready;
    logic [DW-1:0]   cmd_tdata;
    logic            cmd_tvalid, cmd_tlast, cmd_tready;
    logic [RW-1:0]   rsp_tdata;
    logic            rsp_tvalid, rsp_tready;
    logic [N*RW-1:0] req_rsp_tdata;
    logic [N-1:0]    req_rsp_tvalid, req_rsp_tready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [7:0]      drop_cnt;

    int checks = 0;
    int errors = 0;

    axis_i2c_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .RD_DATA_WIDTH(RW), .HOLD_CYCLES(H)
    ) dut (
        .clk_i(clk), .arst_i(arst),
        .req_tdata_i(req_tdata), .req_tvalid_i(req_tvalid), .req_tlast_i(req_tlast),
        .req_tready_o(req_tready),
        .cmd_tdata_o(cmd_tdata), .cmd_tvalid_o(cmd_tvalid), .cmd_tlast_o(cmd_tlast),
        .cmd_tready_i(cmd_tready),
        .rsp_tdata_i(rsp_tdata), .rsp_tvalid_i(rsp_tvalid), .rsp_tready_o(rsp_tready),
        .req_rsp_tdata_o(req_rsp_tdata), .req_rsp_tvalid_o(req_rsp_tvalid),
        .req_rsp_tready_i(req_rsp_tready),
        .grant_o(grant), .busy_o(busy), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    // Owner choice: first valid requester at or after ptr, modulo N (ptr forced to 0 for fixed priority).
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        int p;
        p = ptr;
`ifdef ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive_req(input int k, input logic v, input logic [DW-1:0] d, input logic l);
        req_tvalid[k]          = v;
        req_tdata[k*DW +: DW]  = d;
        req_tlast[k]           = l;
    endtask

    task automatic idle_inputs;
        req_tdata      = '0;
        req_tvalid     = '0;
        req_tlast      = '0;
        cmd_tready     = 1'b1;
        rsp_tdata      = '0;
        rsp_tvalid     = 1'b0;
        req_rsp_tready = '0;
    endtask

    task automatic do_reset;
        arst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 arst = 1'b0;
    endtask

    task automatic wait_idle;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(); settle();
            if (grant == '0 && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle grant=%b busy=%b expected idle within 300 cycles", grant, busy);
        end
    endtask

    task automatic test_reset;
        do_reset();
        settle();
        checks++;
        if (grant !== '0 || busy !== 1'b0 || drop_cnt !== 8'd0 || cmd_tvalid !== 1'b0 ||
            req_tready !== '0 || req_rsp_tvalid !== '0 || rsp_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset grant=%b busy=%b drop=%0d cvalid=%b rdy=%b rspv=%b rsprdy=%b expected 0,0,0,0,0,0,1",
                     grant, busy, drop_cnt, cmd_tvalid, req_tready, req_rsp_tvalid, rsp_tready);
        end
    endtask

    task automatic test_three_beat;
        logic [DW-1:0] d [3];
        logic [N-1:0]  exp_g;
        d[0] = 16'h5A01; d[1] = 16'h5A02; d[2] = 16'h5A03;
        step(); drive_req(1, 1'b1, d[0], 1'b0); settle();
        checks++;
        if (grant !== '0) begin
            errors++;
            $display("FAIL three_beat_latency grant=%b expected 0000 in request cycle", grant);
        end
        for (int b = 0; b < 3; b++) begin
            step(); drive_req(1, 1'b1, d[b], b == 2); settle();
            checks++;
            if (grant !== 4'b0010 || cmd_tvalid !== 1'b1 || cmd_tdata !== d[b] ||
                cmd_tlast !== (b == 2) || req_tready !== 4'b0010) begin
                errors++;
                $display("FAIL three_beat_b%0d grant=%b v=%b data=%h last=%b rdy=%b expected 0010 1 %h %0d 0010",
                         b, grant, cmd_tvalid, cmd_tdata, cmd_tlast, req_tready, d[b], b == 2);
            end
        end
        for (int k = 1; k <= H + 1; k++) begin
            step();
            if (k == 1) drive_req(1, 1'b0, '0, 1'b0);
            settle();
            exp_g = (k <= H) ? 4'b0010 : 4'b0000;
            checks++;
            if (grant !== exp_g || busy !== (k <= H) || cmd_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL three_beat_hold k=%0d grant=%b busy=%b v=%b expected %b %0d 0",
                         k, grant, busy, cmd_tvalid, exp_g, k <= H);
            end
        end
        $display("three_beat: done");
    endtask

    task automatic test_round_robin;
        int ptr, exp, seen, zero_run;
        logic [N-1:0] prev;
        do_reset();
        for (int k = 0; k < N; k++) drive_req(k, 1'b1, DW'(16'h1000 + k), 1'b1);
        ptr = 0; seen = 0; zero_run = 0; prev = '0;
        for (int c = 0; c < 6 * (H + 3) && seen < 5; c++) begin
            step(); settle();
            if (grant == '0) zero_run++;
            else if (prev == '0) begin
                exp = pick(4'b1111, ptr);
                ptr = (exp + 1) % N;
                checks++;
                if (grant !== onehot(exp) || cmd_tdata !== DW'(16'h1000 + exp) || (seen > 0 && zero_run != 1)) begin
                    errors++;
                    $display("FAIL rr_grant%0d grant=%b data=%h idle_gap=%0d expected %b %h gap 1",
                             seen, grant, cmd_tdata, zero_run, onehot(exp), DW'(16'h1000 + exp));
                end
                $display("rr: grant %0d -> %b", seen, grant);
                seen++;
                zero_run = 0;
            end
            prev = grant;
        end
        checks++;
        if (seen != 5) begin
            errors++;
            $display("FAIL rr_count grants=%0d expected 5", seen);
        end
        step(); req_tvalid = '0; req_tlast = '0;
        wait_idle();
    endtask

    task automatic test_response;
        logic [N*RW-1:0] exp_bus;
        logic [N-1:0]    exp_g;
        exp_bus = {N{8'hA5}};
        step(); drive_req(2, 1'b1, 16'h2222, 1'b1); settle();
        step(); settle();
        checks++;
        if (grant !== 4'b0100 || cmd_tvalid !== 1'b1 || cmd_tlast !== 1'b1) begin
            errors++;
            $display("FAIL rsp_grant grant=%b v=%b last=%b expected 0100 1 1", grant, cmd_tvalid, cmd_tlast);
        end
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 1) drive_req(2, 1'b0, '0, 1'b0);
            settle();
        end
        for (int i = 20; i <= 23; i++) begin
            step();
            rsp_tvalid = 1'b1; rsp_tdata = 8'hA5;
            req_rsp_tready = (i < 23) ? 4'b1011 : 4'b0100;
            settle();
            checks++;
            if (req_rsp_tvalid !== 4'b0100 || req_rsp_tdata !== exp_bus || rsp_tready !== (i == 23) ||
                grant !== 4'b0100) begin
                errors++;
                $display("FAIL rsp_route i=%0d rspv=%b data=%h rdy=%b grant=%b expected 0100 %h %0d 0100",
                         i, req_rsp_tvalid, req_rsp_tdata, rsp_tready, grant, exp_bus, i == 23);
            end
        end
        for (int k = 1; k <= H + 1; k++) begin
            step();
            rsp_tvalid = 1'b0; rsp_tdata = '0; req_rsp_tready = '0;
            settle();
            exp_g = (k <= H) ? 4'b0100 : 4'b0000;
            checks++;
            if (grant !== exp_g) begin
                errors++;
                $display("FAIL rsp_reload k=%0d grant=%b expected %b", k, grant, exp_g);
            end
        end
        $display("response: done");
    endtask

    task automatic test_drop;
        int m_drop;
        m_drop = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            rsp_tvalid = 1'b1; rsp_tdata = RW'($urandom); req_rsp_tready = N'($urandom);
            settle();
            checks++;
            if (req_rsp_tvalid !== '0 || rsp_tready !== 1'b1 || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL drop i=%0d rspv=%b rdy=%b cnt=%0d expected 0000 1 %0d",
                         i, req_rsp_tvalid, rsp_tready, drop_cnt, m_drop);
            end
            if (m_drop < 255) m_drop++;
        end
        step(); rsp_tvalid = 1'b0; req_rsp_tready = '0; settle();
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_sat cnt=%0d expected 255", drop_cnt);
        end
        $display("drop: count %0d", drop_cnt);
    endtask

    task automatic test_mid_reset;
        step(); drive_req(1, 1'b1, 16'h1111, 1'b1); settle();
        step(); settle();
        step(); drive_req(1, 1'b0, '0, 1'b0); settle();
        wait_idle();
        step(); drive_req(3, 1'b1, 16'h3000, 1'b0); settle();
        for (int b = 0; b < 2; b++) begin
            step(); drive_req(3, 1'b1, DW'(16'h3000 + b), 1'b0); settle();
            checks++;
            if (grant !== 4'b1000 || cmd_tdata !== DW'(16'h3000 + b)) begin
                errors++;
                $display("FAIL midrst_beat%0d grant=%b data=%h expected 1000 %h", b, grant, cmd_tdata, DW'(16'h3000 + b));
            end
        end
        step(); drive_req(3, 1'b1, 16'h3002, 1'b0); settle();
        #1 arst = 1'b1;
        #1;
        checks++;
        if (cmd_tvalid !== 1'b0 || grant !== '0 || busy !== 1'b0 || req_tready !== '0) begin
            errors++;
            $display("FAIL midrst_async v=%b grant=%b busy=%b rdy=%b expected 0 0000 0 0000",
                     cmd_tvalid, grant, busy, req_tready);
        end
        for (int k = 0; k < N; k++) drive_req(k, 1'b1, DW'(16'h7000 + k), 1'b1);
        @(posedge clk);
        #3 arst = 1'b0;
        step(); settle();
        checks++;
        if (grant !== onehot(pick(4'b1111, 0)) || cmd_tdata !== 16'h7000) begin
            errors++;
            $display("FAIL midrst_prio grant=%b data=%h expected %b 7000", grant, cmd_tdata, onehot(pick(4'b1111, 0)));
        end
        step(); req_tvalid = '0; req_tlast = '0; settle();
        wait_idle();
        $display("mid_reset: done");
    endtask

    task automatic test_stall;
        bit released;
        step(); drive_req(0, 1'b1, 16'h4000, 1'b0); settle();
        step(); settle();
        checks++;
        if (grant !== 4'b0001 || cmd_tdata !== 16'h4000) begin
            errors++;
            $display("FAIL stall_grant grant=%b data=%h expected 0001 4000", grant, cmd_tdata);
        end
        step(); drive_req(0, 1'b0, '0, 1'b0); drive_req(3, 1'b1, 16'h8003, 1'b1); settle();
        for (int i = 0; i < 50; i++) begin
            if (i > 0) begin step(); settle(); end
            checks++;
            if (grant !== 4'b0001 || req_tready[3] !== 1'b0 || cmd_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold i=%0d grant=%b rdy3=%b v=%b expected 0001 0 0",
                         i, grant, req_tready[3], cmd_tvalid);
            end
        end
        step(); drive_req(0, 1'b1, 16'h4001, 1'b0); settle();
        step(); drive_req(0, 1'b1, 16'h4002, 1'b1); settle();
        checks++;
        if (grant !== 4'b0001 || cmd_tdata !== 16'h4002 || cmd_tlast !== 1'b1) begin
            errors++;
            $display("FAIL stall_last grant=%b data=%h last=%b expected 0001 4002 1", grant, cmd_tdata, cmd_tlast);
        end
        step(); drive_req(0, 1'b0, '0, 1'b0); settle();
        released = 1'b0;
        for (int i = 0; i < H + 5 && !released; i++) begin
            step(); settle();
            if (grant == '0) released = 1'b1;
        end
        step(); settle();
        checks++;
        if (!released || grant !== onehot(pick(4'b1000, 1))) begin
            errors++;
            $display("FAIL stall_next released=%0d grant=%b expected 1 %b", released, grant, onehot(pick(4'b1000, 1)));
        end
        step(); drive_req(3, 1'b0, '0, 1'b0); settle();
        wait_idle();
        $display("stall: done");
    endtask

    task automatic test_random;
        logic [DW:0]  q [N][$];
        int           m_owner, m_release, m_ptr, len, total;
        bit           m_done, prev_free, all_empty;
        logic [N-1:0] prev_valid, exp_g;
        do_reset();
        total = 0;
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 2; t++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) q[k].push_back({b == len - 1, DW'($urandom)});
                total++;
            end
        end
        m_owner = -1; m_done = 1'b0; m_release = 0; m_ptr = 0;
        prev_free = 1'b1; prev_valid = '0;
        all_empty = 1'b0;
        for (int c = 0; c < 5000 && !(all_empty && m_owner < 0); c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (q[k].size() > 0) drive_req(k, ($urandom % 4) != 0, q[k][0][DW-1:0], q[k][0][DW]);
                else drive_req(k, 1'b0, '0, 1'b0);
            end
            cmd_tready = ($urandom % 4) != 0;
            settle();
            if (m_owner >= 0 && m_done && c >= m_release) m_owner = -1;
            if (m_owner < 0 && prev_free && prev_valid != '0) begin
                m_owner = pick(prev_valid, m_ptr);
                m_done  = 1'b0;
                $display("random: cycle %0d grant to %0d", c, m_owner);
            end
            exp_g = onehot(m_owner);
            checks++;
            if (grant !== exp_g || busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rand_grant c=%0d grant=%b busy=%b expected %b %0d", c, grant, busy, exp_g, m_owner >= 0);
            end
            if (m_owner >= 0 && !m_done) begin
                checks++;
                if (cmd_tvalid !== req_tvalid[m_owner] || req_tready !== (exp_g & {N{cmd_tready}})) begin
                    errors++;
                    $display("FAIL rand_fwd c=%0d v=%b rdy=%b expected %b %b", c, cmd_tvalid, req_tready,
                             req_tvalid[m_owner], exp_g & {N{cmd_tready}});
                end
                if (req_tvalid[m_owner] && cmd_tready) begin
                    checks++;
                    if (cmd_tdata !== q[m_owner][0][DW-1:0] || cmd_tlast !== q[m_owner][0][DW]) begin
                        errors++;
                        $display("FAIL rand_beat c=%0d data=%h last=%b expected %h %b", c, cmd_tdata, cmd_tlast,
                                 q[m_owner][0][DW-1:0], q[m_owner][0][DW]);
                    end
                    if (q[m_owner][0][DW]) begin
                        m_done    = 1'b1;
                        m_release = c + H + 1;
                        m_ptr     = (m_owner + 1) % N;
                    end
                    void'(q[m_owner].pop_front());
                end
            end else begin
                checks++;
                if (cmd_tvalid !== 1'b0 || req_tready !== '0) begin
                    errors++;
                    $display("FAIL rand_quiet c=%0d v=%b rdy=%b expected 0 0000", c, cmd_tvalid, req_tready);
                end
            end
            prev_free  = (m_owner < 0);
            prev_valid = req_tvalid;
            all_empty  = 1'b1;
            for (int k = 0; k < N; k++) if (q[k].size() > 0) all_empty = 1'b0;
        end
        checks++;
        if (!all_empty || m_owner >= 0) begin
            errors++;
            $display("FAIL rand_drain empty=%0d owner=%0d expected 1 -1", all_empty, m_owner);
        end
        $display("random: %0d transactions", total);
    endtask

    initial begin
        arst = 1'b1;
        idle_inputs();
        test_reset();
        test_three_beat();
        test_round_robin();
        test_response();
        test_drop();
        test_mid_reset();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
